// File: rtl/axi4_lite_if.sv
// AXI4-Lite signal bundle shared by the command master and any slave model.
// Each modport lists the directions as seen from that side of the link.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Turns single read/write commands into AXI4-Lite transactions, one at a time,
// and returns each slave response with a saturating count of error responses.
module axi4_lite_cmd_master #(
    parameter int ADDR_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [31:0]              cmd_wdata,
    input  logic [3:0]               cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [31:0]              rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    axi4_lite_if.master              m_axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    running;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic                    write_q;
    logic                    aw_done;
    logic                    w_done;

    logic                    cmd_fire;
    logic                    aw_fire;
    logic                    w_fire;
    logic                    b_fire;
    logic                    ar_fire;
    logic                    r_fire;
    logic                    rsp_fire;
    logic [1:0]              cap_resp;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign aw_fire  = m_axi.awvalid && m_axi.awready;
    assign w_fire   = m_axi.wvalid && m_axi.wready;
    assign b_fire   = m_axi.bvalid && m_axi.bready;
    assign ar_fire  = m_axi.arvalid && m_axi.arready;
    assign r_fire   = m_axi.rvalid && m_axi.rready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign cap_resp = b_fire ? m_axi.bresp : m_axi.rresp;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_next = cmd_write ? WR : RD_ADDR;
                end
            end
            WR: begin
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_fire) begin
                    state_next = RESP;
                end
            end
            RD_ADDR: begin
                if (ar_fire) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_fire) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every handshake signal comes from registered state only, never from a READY input.
    always_comb begin
        cmd_ready     = (state == IDLE) && running;
        rsp_valid     = (state == RESP);
        m_axi.awvalid = (state == WR) && !aw_done;
        m_axi.wvalid  = (state == WR) && !w_done;
        m_axi.bready  = (state == WR_RESP);
        m_axi.arvalid = (state == RD_ADDR);
        m_axi.rready  = (state == RD_DATA);
        m_axi.awaddr  = addr_q;
        m_axi.araddr  = addr_q;
        m_axi.awprot  = 3'b000;
        m_axi.arprot  = 3'b000;
        m_axi.wdata   = wdata_q;
        m_axi.wstrb   = wstrb_q;
    end

    // running holds cmd_ready low until one full cycle has passed out of reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            running   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            err_count <= '0;
        end else begin
            running <= 1'b1;
            if (cmd_fire) begin
                addr_q  <= cmd_addr & ~ADDR_WIDTH'(3);
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                write_q <= cmd_write;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_done <= 1'b1;
                end
                if (w_fire) begin
                    w_done <= 1'b1;
                end
            end
            if (b_fire || r_fire) begin
                rsp_write <= write_q;
                rsp_resp  <= cap_resp;
                rsp_rdata <= b_fire ? 32'h0 : m_axi.rdata;
                if ((cap_resp != 2'b00) && (err_count != '1)) begin
                    err_count <= err_count + ERR_CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed and randomized-backpressure bench for axi4_lite_cmd_master,
// with a behavioral AXI4-Lite slave and a protocol monitor alongside.
module tb_axi4_lite_cmd_master;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [1:0]  err_count;

    int tests = 0;
    int fails = 0;

    axi4_lite_if #(.ADDR_WIDTH(32)) axi ();

    axi4_lite_cmd_master #(
        .ADDR_WIDTH    (32),
        .ERR_CNT_WIDTH (2)
    ) dut (
        .ACLK      (aclk),
        .ARESETn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .err_count (err_count),
        .m_axi     (axi)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model configuration and observations
    bit          rand_mode = 1'b0;
    bit          b_hold = 1'b0;
    int          aw_delay = 0;
    int          w_delay = 0;
    int          b_delay = 0;
    int          r_delay = 0;
    logic [1:0]  wr_resp_cfg = 2'b00;
    logic [1:0]  rd_resp_cfg = 2'b00;
    logic [1:0]  slv_last_resp = 2'b00;
    logic [31:0] slv_mem [16];
    logic [31:0] got_awaddr = '0;
    logic [31:0] got_araddr = '0;
    logic [31:0] got_wdata = '0;
    logic [3:0]  got_wstrb = '0;
    int          b_count = 0;

    bit          aw_got, w_got, b_pend, r_pend;
    int          aw_cnt, w_cnt, b_wait, r_wait;
    bit          p_rst, p_aw_hs, p_aw_pend, p_w_hs, p_w_pend, p_ar_hs, p_ar_pend, p_b_hs, p_r_hs;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    logic [3:0]  p_wstrb;

    function automatic logic [1:0] pick_resp(input logic [1:0] cfg);
        int r;
        if (!rand_mode) return cfg;
        r = $urandom_range(0, 7);
        return (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : 2'b00;
    endfunction

    // Slave: samples handshakes just before each edge, reacts 1 time unit after it.
    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        for (int i = 0; i < 16; i++) slv_mem[i] = '0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_wait = 0; r_wait = 0;
        forever begin
            @(posedge aclk);
            p_rst     = (aresetn === 1'b1);
            p_aw_hs   = axi.awvalid && axi.awready;
            p_aw_pend = axi.awvalid && !axi.awready;
            p_w_hs    = axi.wvalid && axi.wready;
            p_w_pend  = axi.wvalid && !axi.wready;
            p_ar_hs   = axi.arvalid && axi.arready;
            p_ar_pend = axi.arvalid && !axi.arready;
            p_b_hs    = axi.bvalid && axi.bready;
            p_r_hs    = axi.rvalid && axi.rready;
            p_awaddr  = axi.awaddr;
            p_araddr  = axi.araddr;
            p_wdata   = axi.wdata;
            p_wstrb   = axi.wstrb;
            #1;
            if (!p_rst) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0;
                axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
                axi.bvalid = 1'b0; axi.rvalid = 1'b0;
            end else begin
                if (p_aw_pend) begin
                    check("awvalid_hold", axi.awvalid, 1);
                    check("awaddr_stable", axi.awaddr, p_awaddr);
                end
                if (p_w_pend) begin
                    check("wvalid_hold", axi.wvalid, 1);
                    check("wdata_stable", axi.wdata, p_wdata);
                    check("wstrb_stable", axi.wstrb, p_wstrb);
                end
                if (p_ar_pend) begin
                    check("arvalid_hold", axi.arvalid, 1);
                    check("araddr_stable", axi.araddr, p_araddr);
                end
                if (p_aw_hs) check("awvalid_drop", axi.awvalid, 0);
                if (p_w_hs) check("wvalid_drop", axi.wvalid, 0);
                if (p_ar_hs) check("arvalid_drop", axi.arvalid, 0);

                if (p_aw_hs) begin aw_got = 1; got_awaddr = p_awaddr; aw_cnt = 0; end
                if (p_w_hs) begin w_got = 1; got_wdata = p_wdata; got_wstrb = p_wstrb; w_cnt = 0; end
                if (aw_got && w_got) begin
                    for (int b = 0; b < 4; b++)
                        if (got_wstrb[b]) slv_mem[got_awaddr[5:2]][b*8 +: 8] = got_wdata[b*8 +: 8];
                    aw_got = 0; w_got = 0; b_pend = 1;
                    b_wait = rand_mode ? $urandom_range(0, 3) : b_delay;
                end
                if (p_b_hs) begin axi.bvalid = 1'b0; b_count++; end
                if (b_pend && !b_hold) begin
                    if (b_wait == 0) begin
                        axi.bvalid = 1'b1;
                        axi.bresp = pick_resp(wr_resp_cfg);
                        slv_last_resp = axi.bresp;
                        b_pend = 0;
                    end else b_wait--;
                end
                if (p_ar_hs) begin
                    got_araddr = p_araddr; r_pend = 1;
                    r_wait = rand_mode ? $urandom_range(0, 3) : r_delay;
                end
                if (p_r_hs) axi.rvalid = 1'b0;
                if (r_pend) begin
                    if (r_wait == 0) begin
                        axi.rvalid = 1'b1;
                        axi.rdata = slv_mem[got_araddr[5:2]];
                        axi.rresp = pick_resp(rd_resp_cfg);
                        slv_last_resp = axi.rresp;
                        r_pend = 0;
                    end else r_wait--;
                end
                if (rand_mode) begin
                    axi.awready = ($urandom_range(0, 2) != 0);
                    axi.wready  = ($urandom_range(0, 2) != 0);
                    axi.arready = ($urandom_range(0, 2) != 0);
                end else begin
                    axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
                    axi.wready  = axi.wvalid && (w_cnt >= w_delay);
                    axi.arready = axi.arvalid;
                    if (axi.awvalid) aw_cnt++;
                    if (axi.wvalid) w_cnt++;
                end
            end
        end
    end

    logic        obs_write;
    logic [31:0] obs_rdata;
    logic [1:0]  obs_resp;
    logic [31:0] ref_mem [16];
    logic [1:0]  exp_err;

    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input int hold, input string tag);
        int n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        check({tag, "_accept"}, cmd_ready, 1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin @(posedge aclk); #1; n++; end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        obs_write = rsp_write; obs_rdata = rsp_rdata; obs_resp = rsp_resp;
        if (hold > 0) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3C;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_rdata"}, rsp_rdata, obs_rdata);
            check({tag, "_hold_resp"}, rsp_resp, obs_resp);
            check({tag, "_hold_write"}, rsp_write, obs_write);
            check({tag, "_hold_no_accept"}, cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge aclk); #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, rsp_valid, 0);
        check({tag, "_ready_again"}, cmd_ready, 1);
    endtask

    task automatic checkOutput(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input string tag);
        logic [31:0] exp_rdata;
        exp_rdata = 32'h0;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr[5:2]][b*8 +: 8] = wdata[b*8 +: 8];
            check({tag, "_awaddr"}, got_awaddr, {addr[31:2], 2'b00});
            check({tag, "_wdata"}, got_wdata, wdata);
            check({tag, "_wstrb"}, got_wstrb, strb);
        end else begin
            exp_rdata = ref_mem[addr[5:2]];
            check({tag, "_araddr"}, got_araddr, {addr[31:2], 2'b00});
        end
        if (slv_last_resp != 2'b00 && exp_err != 2'b11) exp_err = exp_err + 2'd1;
        check({tag, "_rsp_write"}, obs_write, wr);
        check({tag, "_rsp_rdata"}, obs_rdata, exp_rdata);
        check({tag, "_rsp_resp"}, obs_resp, slv_last_resp);
        check({tag, "_err_count"}, err_count, exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bc;
        int n;
        bit wr;
        logic [31:0] a, d;
        logic [3:0] s;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        exp_err = 2'b00;

        // Reset held three cycles while a command is offered
        aresetn = 1'b0; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5A5A5; cmd_wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_awvalid", axi.awvalid, 0);
        end
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_write", rsp_write, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_err_count", err_count, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_rready", axi.rready, 0);
        aresetn = 1'b1; cmd_valid = 1'b0;
        @(posedge aclk); #1;
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_no_write", b_count, 0);

        // Unaligned write, AWREADY two cycles behind WREADY
        aw_delay = 2; w_delay = 0;
        bc = b_count;
        applyStimulus(1'b1, 32'h07, 32'hDEADBEEF, 4'b0101, 0, "wr07");
        checkOutput(1'b1, 32'h07, 32'hDEADBEEF, 4'b0101, "wr07");
        check("wr07_awaddr_aligned", got_awaddr, 32'h04);
        check("wr07_single_b", b_count - bc, 1);
        aw_delay = 0;

        // Write then read back with response held off five cycles
        applyStimulus(1'b1, 32'h00, 32'h12345678, 4'hF, 0, "wr00");
        checkOutput(1'b1, 32'h00, 32'h12345678, 4'hF, "wr00");
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, 5, "rd00");
        checkOutput(1'b0, 32'h00, 32'h0, 4'h0, "rd00");
        check("rd00_data", obs_rdata, 32'h12345678);
        check("wr07_readback", ref_mem[1], 32'h00AD00EF);

        // Error counter saturates at 3 with a 2-bit width
        rd_resp_cfg = 2'b10;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, 0, "rderr");
            checkOutput(1'b0, 32'h00, 32'h0, 4'h0, "rderr");
            check("rderr_seq", err_count, (i < 3) ? i + 1 : 3);
        end
        rd_resp_cfg = 2'b00;

        // Reset while waiting for the write response
        b_hold = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (axi.bready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        check("mid_bready_up", axi.bready, 1);
        ref_mem[8] = 32'hCAFEF00D;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check("mid_bready_low", axi.bready, 0);
        check("mid_err_count", err_count, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_wvalid", axi.wvalid, 0);
        exp_err = 2'b00;
        aresetn = 1'b1; b_hold = 1'b0;
        @(posedge aclk); #1;
        check("mid_ready_again", cmd_ready, 1);
        applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, 0, "midrd");
        checkOutput(1'b0, 32'h00, 32'h0, 4'h0, "midrd");
        check("midrd_data", obs_rdata, 32'h12345678);

        // Mixed traffic under random READY stalls and random responses
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wr = $urandom_range(0, 1);
            a = $urandom_range(0, 63);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            applyStimulus(wr, a, d, s, $urandom_range(0, 2), "rnd");
            checkOutput(wr, a, d, s, "rnd");
        end
        rand_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4_lite_cmd_master.md
AXI4_LITE_CMD_MASTER -- requirements
Module: axi4_lite_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of the command address and of AWADDR/ARADDR.
REQ-002 SHALL have parameter ERR_CNT_WIDTH, default 16: width of the error counter.
REQ-003 SHALL have port ACLK  in  1: single clock; all logic samples on its rising edge.
REQ-004 SHALL have port ARESETn  in  1: reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  in  1: command offered.
REQ-006 SHALL have port cmd_ready  out  1: command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_write  in  1: 1 selects write, 0 selects read.
REQ-008 SHALL have port cmd_addr  in  ADDR_WIDTH: byte address.
REQ-009 SHALL have port cmd_wdata  in  32: write data.
REQ-010 SHALL have port cmd_wstrb  in  4: write byte strobes.
REQ-011 SHALL have port rsp_valid  out  1: response available.
REQ-012 SHALL have port rsp_ready  in  1: response consumed when high together with rsp_valid.
REQ-013 SHALL have port rsp_write  out  1: echo of cmd_write.
REQ-014 SHALL have port rsp_rdata  out  32: read data; 0 for writes.
REQ-015 SHALL have port rsp_resp  out  2: BRESP or RRESP as returned by the slave.
REQ-016 SHALL have port err_count  out  ERR_CNT_WIDTH: saturating count of non-OKAY responses.
REQ-017 SHALL have port m_axi  master  axi4_lite_if: AXI4-Lite master driving the AW/W/B/AR/R channels; AWPROT and ARPROT tied to 3'b000.

Function
REQ-018 SHALL implement FSM states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP; only one transaction outstanding at any time.
REQ-019 SHALL drive cmd_ready high only in IDLE; on accept, SHALL register addr, wdata, wstrb and write into internal holding registers.
REQ-020 SHALL on accept go to WR (cmd_write=1) or RD_ADDR (cmd_write=0); AWVALID+WVALID or ARVALID SHALL be high on the next cycle, from registers.
REQ-021 SHALL drive AWADDR and ARADDR as {addr[ADDR_WIDTH-1:2],2'b00}, and WDATA/WSTRB from the holding registers, stable while VALID is high.
REQ-022 SHALL in WR deassert AWVALID and WVALID independently, each on the cycle after its own handshake; AW and W completing in either order or together SHALL be supported.
REQ-023 SHALL leave WR for WR_RESP once both AW and W handshakes have completed; SHALL hold BREADY=1 in WR_RESP only.
REQ-024 SHALL in RD_ADDR hold ARVALID until the ARREADY handshake, then go to RD_DATA with RREADY=1 in RD_DATA only.
REQ-025 SHALL on the BVALID or RVALID handshake capture rsp_resp (and RDATA for reads; rsp_rdata=0 for writes), then go to RESP with rsp_valid=1 on the next cycle.
REQ-026 SHALL hold rsp_valid and all rsp_* outputs stable in RESP until rsp_ready; SHALL return to IDLE on that handshake, so the next command can be accepted one cycle later.
REQ-027 SHALL increment err_count by 1 on each B/R capture with resp!=2'b00, and SHALL saturate at all-ones without wrapping.
REQ-028 SHALL never assert a VALID without holding it until its READY; VALID SHALL not depend combinationally on READY.

Reset
REQ-029 SHALL, while ARESETn=0 at a clock edge, enter IDLE and drive cmd_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_resp=0, err_count=0, AWVALID=WVALID=ARVALID=BREADY=RREADY=0.
REQ-030 SHALL abandon any in-flight transaction on reset without completing it; cmd_ready SHALL rise on the first cycle after ARESETn returns to 1.

Verification
REQ-031 Reset: hold ARESETn=0 for 3 cycles with cmd_valid=1 -> no handshake occurs; all outputs at REQ-029 values; cmd_ready=1 one cycle after release.
REQ-032 Write: cmd write addr=0x07, wdata=0xDEADBEEF, wstrb=4'b0101, slave AWREADY delayed 2 cycles beyond WREADY -> AWADDR=0x04; single write response; rsp_write=1, rsp_resp=0, rsp_rdata=0.
REQ-033 Read: write 0x12345678 to 0x00, then read 0x00 with rsp_ready held low 5 cycles -> rsp_rdata=0x12345678 stable until handshake; no new command accepted meanwhile.
REQ-034 Error saturation: ERR_CNT_WIDTH=2, four reads answered RRESP=2'b10 -> err_count sequence 1,2,3,3.
REQ-035 Backpressure protocol: random READY stalls over 1000 mixed commands -> every VALID held until handshake, AW/W/AR payloads stable, responses in command order.
REQ-036 Mid-transaction reset: assert ARESETn=0 in WR_RESP before BVALID -> BREADY=0 and IDLE next cycle; err_count=0; subsequent read completes normally.
